// File: rtl/note_seq_classifier.sv
// Programmable note-sequence classifier: matches a terminated stream of {tom,nota}
// symbols against NUM_CLS stored patterns and reports the lowest matching class.
module note_seq_classifier #(
    parameter  int NOTE_W  = 3,
    parameter  int MAX_LEN = 8,
    parameter  int NUM_CLS = 4,
    parameter  int CLS_W   = 2,
    localparam int POS_W   = $clog2(MAX_LEN + 1),
    localparam int SYM_W   = NOTE_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ok,
    input  logic              tom,
    input  logic [NOTE_W-1:0] nota,
    input  logic              prog_we,
    input  logic [CLS_W-1:0]  prog_cls,
    input  logic [POS_W-1:0]  prog_idx,
    input  logic [SYM_W-1:0]  prog_data,
    output logic              fim,
    output logic              hit,
    output logic [CLS_W-1:0]  tipo,
    output logic [POS_W-1:0]  pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_next;
    logic [SYM_W-1:0]   pat [NUM_CLS][MAX_LEN];
    logic [POS_W-1:0]   len [NUM_CLS];
    logic [NUM_CLS-1:0] cand, cand_next, cand_step, len_hit, pat_match;
    logic [POS_W-1:0]   pos_next;
    logic               hit_next;
    logic [CLS_W-1:0]   tipo_next;
    logic               win_found;
    logic [CLS_W-1:0]   win_cls;

    logic [SYM_W-1:0]       sym;
    logic                   prog_take;
    logic                   prog_valid;
    logic [POS_W+SYM_W-1:0] data_ext;
    logic [POS_W-1:0]       len_raw;
    logic [POS_W-1:0]       len_wr;

    assign sym = {tom, nota};

    // A write in IDLE always consumes the cycle, even when its address is out of range.
    assign prog_take  = prog_we && (state == S_IDLE);
    assign prog_valid = prog_take && (int'(prog_cls) < NUM_CLS) && (int'(prog_idx) <= MAX_LEN);

    assign data_ext = {{POS_W{1'b0}}, prog_data};
    assign len_raw  = data_ext[POS_W-1:0];
    assign len_wr   = (int'(len_raw) > MAX_LEN) ? POS_W'(MAX_LEN) : len_raw;

    // Pattern table; clr leaves it intact, only reset wipes it.
    // NOTE: the table is a register file with a reset because a cleared table (all
    // lengths 0) is the defined power-up behaviour; a plain RAM would come up random.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CLS; c++) begin
                len[c] <= '0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    pat[c][i] <= '0;
                end
            end
        end else if (!clr && prog_valid) begin
            for (int c = 0; c < NUM_CLS; c++) begin
                if (prog_cls == CLS_W'(c)) begin
                    if (int'(prog_idx) == MAX_LEN) begin
                        len[c] <= len_wr;
                    end
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (prog_idx == POS_W'(i)) begin
                            pat[c][i] <= prog_data;
                        end
                    end
                end
            end
        end
    end

    // Per-class match of the incoming symbol at the current position.
    // NOTE: combinational blocks use blocking '=' and assign every target a default
    // first, so the loop-carried values are well defined and no latch is inferred.
    always_comb begin
        pat_match = '0;
        cand_step = '0;
        len_hit   = '0;
        for (int c = 0; c < NUM_CLS; c++) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (pos == POS_W'(i)) begin
                    pat_match[c] = (pat[c][i] == sym);
                end
            end
            cand_step[c] = cand[c] & (pos < len[c]) & pat_match[c];
            len_hit[c]   = cand[c] & (len[c] == pos);
        end
    end

    // Lowest-index class wins when several patterns end at the same length.
    always_comb begin
        win_found = 1'b0;
        win_cls   = '0;
        for (int c = 0; c < NUM_CLS; c++) begin
            if (len_hit[c] && !win_found) begin
                win_found = 1'b1;
                win_cls   = CLS_W'(c);
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values and the block order cannot change the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pos   <= '0;
            cand  <= '1;
            hit   <= 1'b0;
            tipo  <= '0;
        end else begin
            state <= state_next;
            pos   <= pos_next;
            cand  <= cand_next;
            hit   <= hit_next;
            tipo  <= tipo_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        cand_next  = cand;
        hit_next   = hit;
        tipo_next  = tipo;
        if (clr) begin
            state_next = S_IDLE;
            pos_next   = '0;
            cand_next  = '1;
            hit_next   = 1'b0;
            tipo_next  = '0;
        end else if (ok && !prog_take) begin
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (nota != '0) begin
                        if (int'(pos) == MAX_LEN) begin
                            state_next = S_ERROR;
                        end else begin
                            cand_next  = cand_step;
                            pos_next   = pos + POS_W'(1);
                            state_next = (|cand_step) ? S_COLLECT : S_ERROR;
                        end
                    end else if (state == S_COLLECT && win_found) begin
                        state_next = S_DONE;
                        hit_next   = 1'b1;
                        tipo_next  = win_cls;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Output decode; hit, tipo and pos are driven straight from registers.
    always_comb begin
        fim = (state == S_DONE) || (state == S_ERROR);
    end

endmodule

// File: tb/tb_note_seq_classifier.sv
// Directed bench for note_seq_classifier: programs patterns, plays sequences and
// compares the {fim,hit,tipo,pos} status against hand-computed values.
module tb_note_seq_classifier;

    logic       clk = 1'b0;
    logic       reset, clr, ok, tom;
    logic [2:0] nota;
    logic       prog_we;
    logic [1:0] prog_cls;
    logic [3:0] prog_idx;
    logic [3:0] prog_data;
    logic       fim, hit;
    logic [1:0] tipo;
    logic [3:0] pos;

    int errors = 0;
    int checks = 0;

    note_seq_classifier dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .ok        (ok),
        .tom       (tom),
        .nota      (nota),
        .prog_we   (prog_we),
        .prog_cls  (prog_cls),
        .prog_idx  (prog_idx),
        .prog_data (prog_data),
        .fim       (fim),
        .hit       (hit),
        .tipo      (tipo),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic note(input logic t, input logic [2:0] n);
        ok = 1'b1; tom = t; nota = n;
        tick();
        ok = 1'b0; tom = 1'b0; nota = '0;
    endtask

    task automatic prog(input logic [1:0] c, input logic [3:0] i, input logic [3:0] d);
        prog_we = 1'b1; prog_cls = c; prog_idx = i; prog_data = d;
        tick();
        prog_we = 1'b0; prog_cls = '0; prog_idx = '0; prog_data = '0;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic play_do_re_mi_term;
        note(1'b0, 3'd1);
        note(1'b0, 3'd2);
        note(1'b0, 3'd3);
        note(1'b0, 3'd0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b0, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_state: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 0 0 0 0", fim, hit, tipo, pos);
        end
    endtask

    task automatic test_single;
        prog(2'd0, 4'd0, 4'b0001);
        prog(2'd0, 4'd1, 4'b0010);
        prog(2'd0, 4'd2, 4'b0011);
        prog(2'd0, 4'd8, 4'd3);
        note(1'b0, 3'd1);
        note(1'b0, 3'd2);
        repeat (2) tick();
        checks++;
        if ({fim, pos} !== {1'b0, 4'd2}) begin
            errors++;
            $display("FAIL t1_ok_low_hold: got fim=%0d pos=%0d, want fim=0 pos=2", fim, pos);
        end
        note(1'b0, 3'd3);
        note(1'b0, 3'd0);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b1, 2'd0, 4'd3}) begin
            errors++;
            $display("FAIL t1_done: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 1 0 3", fim, hit, tipo, pos);
        end
        do_clr();
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b0, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL t1_clr: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 0 0 0 0", fim, hit, tipo, pos);
        end
    endtask

    task automatic test_two_classes;
        prog(2'd1, 4'd0, 4'b0001);
        prog(2'd1, 4'd1, 4'b0010);
        prog(2'd1, 4'd2, 4'b0011);
        prog(2'd1, 4'd3, 4'b1100);
        prog(2'd1, 4'd8, 4'd4);
        note(1'b0, 3'd1);
        note(1'b0, 3'd2);
        note(1'b0, 3'd3);
        note(1'b1, 3'd4);
        note(1'b0, 3'd0);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b1, 2'd1, 4'd4}) begin
            errors++;
            $display("FAIL t2_cls1: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 1 1 4", fim, hit, tipo, pos);
        end
        do_clr();
        play_do_re_mi_term();
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b1, 2'd0, 4'd3}) begin
            errors++;
            $display("FAIL t2_cls0: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 1 0 3", fim, hit, tipo, pos);
        end
        do_clr();
    endtask

    task automatic test_error;
        note(1'b0, 3'd1);
        note(1'b0, 3'd2);
        note(1'b0, 3'd5);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b0, 2'd0, 4'd3}) begin
            errors++;
            $display("FAIL t3_error: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 0 0 3", fim, hit, tipo, pos);
        end
        note(1'b0, 3'd1);
        note(1'b0, 3'd0);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b0, 2'd0, 4'd3}) begin
            errors++;
            $display("FAIL t3_hold: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 0 0 3", fim, hit, tipo, pos);
        end
        clr = 1'b1; ok = 1'b1; nota = 3'd1;
        tick();
        clr = 1'b0; ok = 1'b0; nota = '0;
        checks++;
        if ({fim, pos} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL t3_clr_over_ok: got fim=%0d pos=%0d, want fim=0 pos=0", fim, pos);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 8; i++) prog(2'd2, 4'(i), 4'b0101);
        prog(2'd2, 4'd8, 4'hF);
        for (int i = 0; i < 8; i++) note(1'b0, 3'd5);
        checks++;
        if ({fim, pos} !== {1'b0, 4'd8}) begin
            errors++;
            $display("FAIL t4_full: got fim=%0d pos=%0d, want fim=0 pos=8", fim, pos);
        end
        note(1'b0, 3'd0);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b1, 2'd2, 4'd8}) begin
            errors++;
            $display("FAIL t4_len_sat: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 1 2 8", fim, hit, tipo, pos);
        end
        do_clr();
        for (int i = 0; i < 9; i++) note(1'b0, 3'd5);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b0, 2'd0, 4'd8}) begin
            errors++;
            $display("FAIL t4_overflow: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 0 0 8", fim, hit, tipo, pos);
        end
        do_clr();
        prog(2'd3, 4'd0, 4'b0001);
        prog(2'd3, 4'd1, 4'b0010);
        prog(2'd3, 4'd2, 4'b0011);
        prog(2'd3, 4'd8, 4'd3);
        prog(2'd0, 4'd9, 4'd1);
        play_do_re_mi_term();
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b1, 2'd0, 4'd3}) begin
            errors++;
            $display("FAIL t4_lowest: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 1 0 3", fim, hit, tipo, pos);
        end
        do_clr();
    endtask

    task automatic test_term_and_prog;
        note(1'b0, 3'd0);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL t5_empty: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 0 0 0", fim, hit, tipo, pos);
        end
        do_clr();
        ok = 1'b1; nota = 3'd1;
        prog(2'd3, 4'd0, 4'b0001);
        ok = 1'b0; nota = '0;
        checks++;
        if ({fim, pos} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL t5_prog_over_ok: got fim=%0d pos=%0d, want fim=0 pos=0", fim, pos);
        end
        note(1'b0, 3'd1);
        prog(2'd0, 4'd1, 4'b0111);
        note(1'b0, 3'd2);
        note(1'b0, 3'd3);
        note(1'b0, 3'd0);
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b1, 2'd0, 4'd3}) begin
            errors++;
            $display("FAIL t5_prog_in_collect: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 1 0 3", fim, hit, tipo, pos);
        end
        do_clr();
    endtask

    task automatic test_reset_mid;
        note(1'b0, 3'd1);
        note(1'b0, 3'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b0, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("FAIL t6_reset: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 0 0 0 0", fim, hit, tipo, pos);
        end
        play_do_re_mi_term();
        checks++;
        if ({fim, hit, tipo, pos} !== {1'b1, 1'b0, 2'd0, 4'd1}) begin
            errors++;
            $display("FAIL t6_table_cleared: got fim=%0d hit=%0d tipo=%0d pos=%0d, want 1 0 0 1", fim, hit, tipo, pos);
        end
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; ok = 1'b0; tom = 1'b0; nota = '0;
        prog_we = 1'b0; prog_cls = '0; prog_idx = '0; prog_data = '0;
        test_reset();
        test_single();
        test_two_classes();
        test_error();
        test_overflow();
        test_term_and_prog();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
